// File: rtl/fp_mac_pkg.sv
// Floating-point definitions shared by the float_MAC multiplier and accumulator:
// operand classes, exception flag bit positions, and bias / special-value helpers.
package fp_mac_pkg;

    typedef enum logic [1:0] {
        CLS_ZERO = 2'd0,
        CLS_NORM = 2'd1,
        CLS_INF  = 2'd2,
        CLS_NAN  = 2'd3
    } fp_class_e;

    localparam int unsigned FLAG_W         = 4;
    localparam int unsigned FLAG_INEXACT   = 0;
    localparam int unsigned FLAG_UNDERFLOW = 1;
    localparam int unsigned FLAG_OVERFLOW  = 2;
    localparam int unsigned FLAG_INVALID   = 3;

    function automatic int unsigned fp_bias(input int unsigned exp_w);
        return (32'd1 << (exp_w - 1)) - 32'd1;
    endfunction

    // Special patterns are built at 64 bits; callers narrow them to their word width.
    function automatic logic [63:0] fp_inf_pat(input logic sign, input int unsigned exp_w,
                                               input int unsigned man_w);
        logic [63:0] v;
        v = ((64'd1 << exp_w) - 64'd1) << man_w;
        v = v | ({63'd0, sign} << (exp_w + man_w));
        return v;
    endfunction

    function automatic logic [63:0] fp_nan_pat(input int unsigned exp_w,
                                               input int unsigned man_w);
        return (((64'd1 << exp_w) - 64'd1) << man_w) | 64'd1;
    endfunction

    // Subnormal encodings classify as zero (flush-to-zero datapath).
    function automatic fp_class_e fp_classify(input logic exp_zero, input logic exp_ones,
                                              input logic frac_nz);
        fp_class_e cls;
        if (exp_zero) begin
            cls = CLS_ZERO;
        end else if (exp_ones) begin
            cls = frac_nz ? CLS_NAN : CLS_INF;
        end else begin
            cls = CLS_NORM;
        end
        return cls;
    endfunction

endpackage

// File: rtl/fp_round_norm.sv
// Stage-2 datapath: normalise the raw significand product and round to nearest-even.
// With FPMUL_FLAGS_EN defined it also reports whether any dropped bit was set.
module fp_round_norm #(
    parameter int unsigned EXP_W = 5,
    parameter int unsigned MAN_W = 10
) (
    input  logic [2*MAN_W+1:0]      i_prod,
    input  logic signed [EXP_W+1:0] i_esum,
    output logic [MAN_W-1:0]        o_frac,
    output logic signed [EXP_W+1:0] o_esum
`ifdef FPMUL_FLAGS_EN
    ,
    output logic                    o_inexact
`endif
);

    localparam int unsigned PW = 2 * MAN_W + 2;
    localparam int unsigned SW = EXP_W + 2;
    localparam logic signed [SW-1:0] ONE_S = SW'(1);

    logic                 w_msb;
    logic [MAN_W-1:0]     w_frac;
    logic                 w_guard;
    logic                 w_sticky;
    logic                 w_roundup;
    logic                 w_carry;
    logic [MAN_W:0]       w_frac_rnd;
    logic signed [SW-1:0] w_esum_n;

    assign w_msb = i_prod[PW-1];

    // Product of two [1,2) significands lies in [1,4); a set MSB means one extra shift.
    always_comb begin
        if (w_msb) begin
            w_frac   = i_prod[PW-2 -: MAN_W];
            w_guard  = i_prod[MAN_W];
            w_sticky = |i_prod[MAN_W-1:0];
            w_esum_n = i_esum + ONE_S;
        end else begin
            w_frac   = i_prod[PW-3 -: MAN_W];
            w_guard  = i_prod[MAN_W-1];
            w_sticky = |i_prod[MAN_W-2:0];
            w_esum_n = i_esum;
        end
    end

    assign w_roundup  = w_guard & (w_sticky | w_frac[0]);
    assign w_frac_rnd = {1'b0, w_frac} + {{MAN_W{1'b0}}, w_roundup};
    assign w_carry    = w_frac_rnd[MAN_W];

    // On carry-out the low bits are already zero, leaving 1.0 at the next exponent.
    assign o_frac = w_frac_rnd[MAN_W-1:0];
    assign o_esum = w_esum_n + $signed({{(SW-1){1'b0}}, w_carry});

`ifdef FPMUL_FLAGS_EN
    assign o_inexact = w_guard | w_sticky;
`endif

endmodule

// File: rtl/fp_mult_pipe.sv
// Three-stage valid/ready floating-point multiplier (flush-to-zero, round-to-nearest-even).
// Defining FPMUL_FLAGS_EN adds the {invalid, overflow, underflow, inexact} flags port.
module fp_mult_pipe
    import fp_mac_pkg::*;
#(
    parameter int unsigned EXP_W = 5,
    parameter int unsigned MAN_W = 10,
    localparam int unsigned FW = 1 + EXP_W + MAN_W
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [FW-1:0]     a,
    input  logic [FW-1:0]     b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [FW-1:0]     result
`ifdef FPMUL_FLAGS_EN
    ,
    output logic [FLAG_W-1:0] flags
`endif
);

    localparam int unsigned PW = 2 * MAN_W + 2;
    localparam int unsigned SW = EXP_W + 2;
    localparam logic signed [SW-1:0] BIAS_S = SW'(fp_bias(EXP_W));
    localparam logic signed [SW-1:0] EMAX_S = SW'((1 << EXP_W) - 1);
    localparam logic [FW-1:0]        NAN_PAT = FW'(fp_nan_pat(EXP_W, MAN_W));

    logic w_adv;

    logic [EXP_W-1:0]     w_ea;
    logic [EXP_W-1:0]     w_eb;
    logic [MAN_W-1:0]     w_fa;
    logic [MAN_W-1:0]     w_fb;
    fp_class_e            w_cls_a;
    fp_class_e            w_cls_b;
    logic signed [SW-1:0] w_esum1;
    logic [PW-1:0]        w_prod1;

    logic                 r_v1;
    logic                 r_sign1;
    fp_class_e            r_cls_a1;
    fp_class_e            r_cls_b1;
    logic signed [SW-1:0] r_esum1;
    logic [PW-1:0]        r_prod1;

    logic [MAN_W-1:0]     w_frac2;
    logic signed [SW-1:0] w_esum2;

    logic                 r_v2;
    logic                 r_sign2;
    fp_class_e            r_cls_a2;
    fp_class_e            r_cls_b2;
    logic signed [SW-1:0] r_esum2;
    logic [MAN_W-1:0]     r_frac2;

    logic                 w_any_nan;
    logic                 w_any_inf;
    logic                 w_any_zero;
    logic                 w_invalid;
    logic                 w_finite;
    logic                 w_ovf;
    logic                 w_unf;
    logic [FW-1:0]        w_res3;

    logic                 r_v3;
    logic [FW-1:0]        r_result;

`ifdef FPMUL_FLAGS_EN
    logic                 w_inexact2;
    logic                 r_inexact2;
    logic [FLAG_W-1:0]    w_flags3;
    logic [FLAG_W-1:0]    r_flags;
`endif

    // Whole pipe moves in lockstep; only a stalled full output stage blocks it.
    assign w_adv     = ~r_v3 | out_ready;
    assign in_ready  = w_adv;
    assign out_valid = r_v3;
    assign result    = r_result;
`ifdef FPMUL_FLAGS_EN
    assign flags     = r_flags;
`endif

    // Stage 1: unpack, classify, exponent sum and full significand product.
    assign w_ea    = a[FW-2 -: EXP_W];
    assign w_eb    = b[FW-2 -: EXP_W];
    assign w_fa    = a[MAN_W-1:0];
    assign w_fb    = b[MAN_W-1:0];
    assign w_cls_a = fp_classify(w_ea == '0, &w_ea, |w_fa);
    assign w_cls_b = fp_classify(w_eb == '0, &w_eb, |w_fb);
    assign w_esum1 = $signed({2'b00, w_ea}) + $signed({2'b00, w_eb}) - BIAS_S;
    assign w_prod1 = PW'({1'b1, w_fa}) * PW'({1'b1, w_fb});

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_v1     <= 1'b0;
            r_sign1  <= 1'b0;
            r_cls_a1 <= CLS_ZERO;
            r_cls_b1 <= CLS_ZERO;
            r_esum1  <= '0;
            r_prod1  <= '0;
        end else if (w_adv) begin
            r_v1     <= in_valid;
            r_sign1  <= a[FW-1] ^ b[FW-1];
            r_cls_a1 <= w_cls_a;
            r_cls_b1 <= w_cls_b;
            r_esum1  <= w_esum1;
            r_prod1  <= w_prod1;
        end
    end

    // Stage 2: normalise and round.
    fp_round_norm #(
        .EXP_W (EXP_W),
        .MAN_W (MAN_W)
    ) u_round_norm (
        .i_prod    (r_prod1),
        .i_esum    (r_esum1),
        .o_frac    (w_frac2),
        .o_esum    (w_esum2)
`ifdef FPMUL_FLAGS_EN
        ,
        .o_inexact (w_inexact2)
`endif
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_v2     <= 1'b0;
            r_sign2  <= 1'b0;
            r_cls_a2 <= CLS_ZERO;
            r_cls_b2 <= CLS_ZERO;
            r_esum2  <= '0;
            r_frac2  <= '0;
`ifdef FPMUL_FLAGS_EN
            r_inexact2 <= 1'b0;
`endif
        end else if (w_adv) begin
            r_v2     <= r_v1;
            r_sign2  <= r_sign1;
            r_cls_a2 <= r_cls_a1;
            r_cls_b2 <= r_cls_b1;
            r_esum2  <= w_esum2;
            r_frac2  <= w_frac2;
`ifdef FPMUL_FLAGS_EN
            r_inexact2 <= w_inexact2;
`endif
        end
    end

    // Stage 3: exception priority NaN > inf > zero > overflow > underflow > normal.
    assign w_any_nan  = (r_cls_a2 == CLS_NAN) | (r_cls_b2 == CLS_NAN);
    assign w_any_inf  = (r_cls_a2 == CLS_INF) | (r_cls_b2 == CLS_INF);
    assign w_any_zero = (r_cls_a2 == CLS_ZERO) | (r_cls_b2 == CLS_ZERO);
    assign w_invalid  = w_any_nan | (w_any_inf & w_any_zero);
    assign w_finite   = ~w_invalid & ~w_any_inf & ~w_any_zero;
    assign w_ovf      = w_finite & (r_esum2 >= EMAX_S);
    assign w_unf      = w_finite & ~w_ovf & (r_esum2[SW-1] | (r_esum2 == '0));

    always_comb begin
        w_res3 = {r_sign2, r_esum2[EXP_W-1:0], r_frac2};
        if (w_invalid) begin
            w_res3 = NAN_PAT;
        end else if (w_any_inf | w_ovf) begin
            w_res3 = FW'(fp_inf_pat(r_sign2, EXP_W, MAN_W));
        end else if (w_any_zero | w_unf) begin
            w_res3 = {r_sign2, {(FW-1){1'b0}}};
        end
    end

`ifdef FPMUL_FLAGS_EN
    always_comb begin
        w_flags3                 = '0;
        w_flags3[FLAG_INVALID]   = w_invalid;
        w_flags3[FLAG_OVERFLOW]  = w_ovf;
        w_flags3[FLAG_UNDERFLOW] = w_unf;
        w_flags3[FLAG_INEXACT]   = w_ovf | w_unf | (w_finite & r_inexact2);
    end
`endif

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_v3     <= 1'b0;
            r_result <= '0;
`ifdef FPMUL_FLAGS_EN
            r_flags  <= '0;
`endif
        end else if (w_adv) begin
            r_v3     <= r_v2;
            r_result <= w_res3;
`ifdef FPMUL_FLAGS_EN
            r_flags  <= w_flags3;
`endif
        end
    end

endmodule

// File: tb/tb_fp_mult_pipe.sv
// Self-checking bench for fp_mult_pipe: directed vectors, backpressure, reset and random
// streams at binary16 and 8/7 widths against an exact-arithmetic reference model.
module tb_fp_mult_pipe;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        sel;
    logic        drv_valid;
    logic [15:0] drv_a;
    logic [15:0] drv_b;
    logic        drv_ready;

    logic        in_ready_h, out_valid_h, in_ready_b, out_valid_b;
    logic [15:0] result_h, result_b;
    logic        mon_in_ready, mon_out_valid;
    logic [15:0] mon_result;
`ifdef FPMUL_FLAGS_EN
    logic [3:0]  flags_h, flags_b, mon_flags;
`endif

    int n_vec = 0;
    int n_err = 0;
    int acc_cnt = 0;
    int out_cnt = 0;
    logic [19:0] exp_q[$];

    always #5 CLK = ~CLK;

    fp_mult_pipe #(.EXP_W(5), .MAN_W(10)) u_dut_h (
        .CLK       (CLK),
        .RESET     (RESET),
        .in_valid  (drv_valid & ~sel),
        .in_ready  (in_ready_h),
        .a         (drv_a),
        .b         (drv_b),
        .out_valid (out_valid_h),
        .out_ready (drv_ready),
        .result    (result_h)
`ifdef FPMUL_FLAGS_EN
        ,
        .flags     (flags_h)
`endif
    );

    fp_mult_pipe #(.EXP_W(8), .MAN_W(7)) u_dut_b (
        .CLK       (CLK),
        .RESET     (RESET),
        .in_valid  (drv_valid & sel),
        .in_ready  (in_ready_b),
        .a         (drv_a),
        .b         (drv_b),
        .out_valid (out_valid_b),
        .out_ready (drv_ready),
        .result    (result_b)
`ifdef FPMUL_FLAGS_EN
        ,
        .flags     (flags_b)
`endif
    );

    assign mon_in_ready  = sel ? in_ready_b : in_ready_h;
    assign mon_out_valid = sel ? out_valid_b : out_valid_h;
    assign mon_result    = sel ? result_b : result_h;
`ifdef FPMUL_FLAGS_EN
    assign mon_flags     = sel ? flags_b : flags_h;
`endif

    function automatic int cur_ew();
        return sel ? 8 : 5;
    endfunction

    function automatic int cur_mw();
        return sel ? 7 : 10;
    endfunction

    // Exact product value, RNE to mw fraction bits at unbounded range, then FTZ/overflow.
    // Returns {invalid, overflow, underflow, inexact, result[15:0]}.
    function automatic logic [19:0] ref_mul(input int ew, input int mw,
                                            input logic [15:0] x, input logic [15:0] y);
        longint emax, bias, ex, ey, fx, fy, p, q, rem, half, e, s;
        int n, sh;
        logic zx, zy, ix, iy, nx, ny;
        logic [15:0] r;
        logic [3:0] f;
        emax = (longint'(1) << ew) - 1;
        bias = (longint'(1) << (ew - 1)) - 1;
        s  = longint'(x[ew+mw] ^ y[ew+mw]);
        ex = longint'(x >> mw) & emax;
        ey = longint'(y >> mw) & emax;
        fx = longint'(x) & ((longint'(1) << mw) - 1);
        fy = longint'(y) & ((longint'(1) << mw) - 1);
        zx = (ex == 0); zy = (ey == 0);
        ix = (ex == emax) && (fx == 0); iy = (ey == emax) && (fy == 0);
        nx = (ex == emax) && (fx != 0); ny = (ey == emax) && (fy != 0);
        f = 4'b0000;
        if (nx || ny || (ix && zy) || (iy && zx)) begin
            r = 16'((emax << mw) | 1);
            f = 4'b1000;
        end else if (ix || iy) begin
            r = 16'((s << (ew + mw)) | (emax << mw));
        end else if (zx || zy) begin
            r = 16'(s << (ew + mw));
        end else begin
            p = ((longint'(1) << mw) + fx) * ((longint'(1) << mw) + fy);
            n = 0;
            for (int i = 0; i < 40; i++) if (p >= (longint'(1) << i)) n = i;
            sh   = n - mw;
            q    = p >> sh;
            rem  = p - (q << sh);
            half = longint'(1) << (sh - 1);
            if (rem > half || (rem == half && q[0])) q = q + 1;
            if (q == (longint'(2) << mw)) begin
                q = q >> 1;
                n = n + 1;
            end
            e = ex + ey - bias + longint'(n) - longint'(2 * mw);
            if (e >= emax) begin
                r = 16'((s << (ew + mw)) | (emax << mw));
                f = 4'b0101;
            end else if (e <= 0) begin
                r = 16'(s << (ew + mw));
                f = 4'b0011;
            end else begin
                r = 16'((s << (ew + mw)) | (e << mw) | (q - (longint'(1) << mw)));
                f = {3'b000, rem != 0};
            end
        end
        return {f, r};
    endfunction

    function automatic logic [15:0] rnd_op(input int ew, input int mw);
        logic [15:0] v;
        int emaxi, e, mode;
        emaxi = (1 << ew) - 1;
        v     = 16'($urandom);
        mode  = int'($urandom_range(0, 9));
        e     = int'($urandom_range(0, emaxi));
        if (mode == 0) e = 0;
        else if (mode == 1) e = emaxi;
        else if (mode == 2) begin
            e = emaxi;
            v = v & ~16'((1 << mw) - 1);
        end
        v = (v & ~16'(emaxi << mw)) | 16'(e << mw);
        return v;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // One clock: record accepted operands into the scoreboard and check any delivered result.
    task automatic tick();
        logic [19:0] e;
        @(negedge CLK);
        if (drv_valid && mon_in_ready) begin
            exp_q.push_back(ref_mul(cur_ew(), cur_mw(), drv_a, drv_b));
            acc_cnt++;
        end
        if (mon_out_valid && drv_ready) begin
            out_cnt++;
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 20'hxxxxx;
            check("sb_result", {16'd0, mon_result}, {16'd0, e[15:0]});
`ifdef FPMUL_FLAGS_EN
            check("sb_flags", {28'd0, mon_flags}, {28'd0, e[19:16]});
`endif
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic run_single(input string tag, input logic [15:0] x, input logic [15:0] y,
                              input logic [15:0] er, input logic [3:0] ef);
        int lat;
        drv_a = x; drv_b = y; drv_valid = 1'b1; drv_ready = 1'b1;
        @(posedge CLK);
        #1;
        drv_valid = 1'b0;
        lat = 1;
        while (!out_valid_h && lat < 10) begin
            @(posedge CLK);
            #1;
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'd3);
        check({tag, "_result"}, {16'd0, result_h}, {16'd0, er});
`ifdef FPMUL_FLAGS_EN
        check({tag, "_flags"}, {28'd0, flags_h}, {28'd0, ef});
`else
        if (ef === 4'bxxxx) $display("note: flags not built");
`endif
        @(posedge CLK);
        #1;
    endtask

    initial begin
        logic [15:0] bp_a[6];
        logic [15:0] bp_b[6];
        int acc0, out0, c;
        logic seen_low;

        sel = 1'b0; drv_valid = 1'b0; drv_a = '0; drv_b = '0; drv_ready = 1'b1;
        RESET = 1'b1;
        #12;
        check("rst_out_valid", {31'd0, out_valid_h}, 32'd0);
        check("rst_result", {16'd0, result_h}, 32'd0);
        check("rst_out_valid_b", {31'd0, out_valid_b}, 32'd0);
`ifdef FPMUL_FLAGS_EN
        check("rst_flags", {28'd0, flags_h}, 32'd0);
`endif
        @(negedge CLK);
        RESET = 1'b0;
        @(posedge CLK);
        #1;
        check("rst_in_ready", {31'd0, in_ready_h}, 32'd1);

        run_single("one_x_1p5", 16'h3C00, 16'h3E00, 16'h3E00, 4'b0000);
        run_single("two_x_3", 16'h4000, 16'h4200, 16'h4600, 4'b0000);
        run_single("rne_tie", 16'h3C01, 16'h3E00, 16'h3E02, 4'b0001);
        run_single("rne_nontie", 16'h3C01, 16'h3C01, 16'h3C02, 4'b0001);
        run_single("overflow", 16'h7BFF, 16'h4000, 16'h7C00, 4'b0101);
        run_single("underflow", 16'h0400, 16'h0400, 16'h0000, 4'b0011);
        run_single("inf_x_zero", 16'h7C00, 16'h0000, 16'h7C01, 4'b1000);
        run_single("neg_inf", 16'hFC00, 16'h3C00, 16'hFC00, 4'b0000);
        run_single("neg_zero", 16'h8000, 16'h3C00, 16'h8000, 4'b0000);

        // Backpressure: six back-to-back pairs, out_ready low for cycles 2..7.
        bp_a = '{16'h3C00, 16'h4000, 16'h3C01, 16'h3C01, 16'h4400, 16'hC000};
        bp_b = '{16'h3E00, 16'h4200, 16'h3E00, 16'h3C01, 16'h4400, 16'h3800};
        acc0 = acc_cnt; out0 = out_cnt; c = 0; seen_low = 1'b0;
        while ((out_cnt - out0) < 6 && c < 60) begin
            drv_valid = (acc_cnt - acc0) < 6;
            drv_a     = bp_a[(acc_cnt - acc0) % 6];
            drv_b     = bp_b[(acc_cnt - acc0) % 6];
            drv_ready = !(c >= 2 && c <= 7);
            #1;
            if (!mon_in_ready && !seen_low) begin
                seen_low = 1'b1;
                check("bp_held_when_full", 32'(acc_cnt - acc0), 32'd3);
            end
            tick();
            c++;
        end
        drv_valid = 1'b0; drv_ready = 1'b1;
        check("bp_in_ready_dropped", {31'd0, seen_low}, 32'd1);
        check("bp_result_count", 32'(out_cnt - out0), 32'd6);
        check("bp_queue_empty", 32'(exp_q.size()), 32'd0);

        // Reset with three operations in flight.
        for (int i = 0; i < 3; i++) begin
            drv_valid = 1'b1; drv_a = 16'h4400; drv_b = 16'(16'h3C00 + i);
            @(posedge CLK);
            #1;
        end
        drv_valid = 1'b0;
        check("rst_mid_full", {31'd0, out_valid_h}, 32'd1);
        RESET = 1'b1;
        #1;
        check("rst_mid_async", {31'd0, out_valid_h}, 32'd0);
        @(posedge CLK);
        #3;
        RESET = 1'b0;
        run_single("post_reset_first", 16'h4000, 16'h4200, 16'h4600, 4'b0000);

        // Random streams with random valid/ready for both configurations.
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            exp_q.delete();
            for (int i = 0; i < 3000; i++) begin
                drv_valid = ($urandom_range(0, 3) != 0);
                drv_a     = rnd_op(cur_ew(), cur_mw());
                drv_b     = rnd_op(cur_ew(), cur_mw());
                drv_ready = ($urandom_range(0, 3) != 0);
                tick();
            end
            drv_valid = 1'b0; drv_ready = 1'b1;
            for (int i = 0; i < 20 && exp_q.size() > 0; i++) tick();
            check(s == 0 ? "rand_h_drained" : "rand_b_drained", 32'(exp_q.size()), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
